// File: rtl/band_fir_sched.sv
`default_nettype none
// ============================================================================
// Module   : band_fir_sched
// Brief    : Shares one signed 16x16 multiply-accumulate engine and one
//            coefficient ROM between the low-band and high-band sample
//            queues. A granted band gets TAPS consecutive read cycles, and its
//            filtered result comes back with a one-cycle valid strobe.
//            Simultaneous requests are resolved round-robin.
//            Build macro BAND_FIR_SAT_EN: when defined, the result saturates
//            to the Q1.15 range. When undefined, the result wraps.
// Revision : 1.0 - initial release
// ============================================================================
module band_fir_sched #(
  parameter int TAPS = 1021,
  parameter int CA_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lf_seq,
  input  logic            hf_seq,
  input  logic [15:0]     lf_smpl,
  input  logic [15:0]     hf_smpl,
  input  logic [15:0]     coeff,
  output logic [CA_W-1:0] coeff_addr,
  output logic            lf_gnt,
  output logic            hf_gnt,
  output logic [15:0]     lf_out,
  output logic [15:0]     hf_out,
  output logic            lf_vld,
  output logic            hf_vld
);

  localparam int TW = $clog2(TAPS);
  localparam int AW = 32 + TW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TW-1:0]        tap_cnt;
  logic                 drain_cnt;
  logic                 sel_hf;
  logic                 last_hf;
  logic                 start;
  logic                 finish;
  logic                 pick_hf;
  logic                 gnt_d;
  logic                 prod_vld;
  logic signed [31:0]   prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [15:0]   smpl_sel;
  logic [15:0]          result;

  // A lone request wins outright; on a tie the band not served last wins.
  assign pick_hf = hf_seq & (~lf_seq | ~last_hf);

  // The second drain cycle is the last point at which a product lands;
  // the result is captured on that edge so the strobe shows up during DONE.
  assign finish = (state == DRAIN) & drain_cnt;

  // Next-state decode for the pass sequencer.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (lf_seq | hf_seq) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN:     if (tap_cnt == TW'(TAPS - 1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the per-pass control: band select, tap and drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      drain_cnt <= 1'b0;
      sel_hf    <= 1'b0;
      last_hf   <= 1'b1;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (start) begin
        sel_hf  <= pick_hf;
        tap_cnt <= '0;
      end else if (state == RUN) begin
        tap_cnt <= tap_cnt + TW'(1);
      end
      if (finish) last_hf <= sel_hf;
    end
  end

  assign lf_gnt     = (state == RUN) & ~sel_hf;
  assign hf_gnt     = (state == RUN) & sel_hf;
  assign coeff_addr = (state != RUN) ? '0 :
                      sel_hf ? (CA_W'(TAPS) + CA_W'(tap_cnt)) : CA_W'(tap_cnt);

  // The band select is frozen for the whole pass, so it safely steers read data.
  assign smpl_sel = sel_hf ? hf_smpl : lf_smpl;
  assign acc_nxt  = prod_vld ? (acc + {{(AW-32){prod[31]}}, prod}) : acc;

  // Multiply-accumulate pipeline: the read data arrives the cycle after its
  // grant, and the product is registered then; it accumulates one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d    <= 1'b0;
      prod_vld <= 1'b0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      gnt_d    <= lf_gnt | hf_gnt;
      prod_vld <= gnt_d;
      prod     <= smpl_sel * $signed(coeff);
      acc      <= start ? '0 : acc_nxt;
    end
  end

`ifdef BAND_FIR_SAT_EN
  logic fits;
  // The result fits in Q1.15 when every bit above bit 30 matches the sign.
  assign fits   = (&acc_nxt[AW-1:30]) | ~(|acc_nxt[AW-1:30]);
  assign result = fits ? acc_nxt[30:15] : (acc_nxt[AW-1] ? 16'h8000 : 16'h7FFF);
`else
  assign result = acc_nxt[30:15];
`endif

  // Result registers and strobes; each band holds its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_out <= '0;
      hf_out <= '0;
      lf_vld <= 1'b0;
      hf_vld <= 1'b0;
    end else begin
      lf_vld <= finish & ~sel_hf;
      hf_vld <= finish & sel_hf;
      if (finish & ~sel_hf) lf_out <= result;
      if (finish & sel_hf)  hf_out <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_band_fir_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_band_fir_sched
// Brief    : Self-checking bench for band_fir_sched (TAPS=4). Queue and ROM
//            memories are modelled with one-cycle read latency. A pass-level
//            reference model predicts grants, addresses, strobes and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_band_fir_sched;

  localparam int TAPS = 4;
  localparam int CA_W = 3;
  localparam int QN   = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lf_seq = 1'b0;
  logic            hf_seq = 1'b0;
  logic [15:0]     lf_smpl = '0;
  logic [15:0]     hf_smpl = '0;
  logic [15:0]     coeff = '0;
  logic [CA_W-1:0] coeff_addr;
  logic            lf_gnt;
  logic            hf_gnt;
  logic [15:0]     lf_out;
  logic [15:0]     hf_out;
  logic            lf_vld;
  logic            hf_vld;

  band_fir_sched #(.TAPS(TAPS), .CA_W(CA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lf_seq     (lf_seq),
    .hf_seq     (hf_seq),
    .lf_smpl    (lf_smpl),
    .hf_smpl    (hf_smpl),
    .coeff      (coeff),
    .coeff_addr (coeff_addr),
    .lf_gnt     (lf_gnt),
    .hf_gnt     (hf_gnt),
    .lf_out     (lf_out),
    .hf_out     (hf_out),
    .lf_vld     (lf_vld),
    .hf_vld     (hf_vld)
  );

  always #5 clk = ~clk;

  logic signed [15:0] lfq [QN];
  logic signed [15:0] hfq [QN];
  logic signed [15:0] rom [2*TAPS];
  int lf_ptr;
  int hf_ptr;
  int checks;
  int errors;

  // reference model state
  bit          active;
  int          t;
  bit          cur_lf;
  bit          last_lf;
  logic [15:0] cur_res;
  logic [15:0] exp_lf_out;
  logic [15:0] exp_hf_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick(input int mode);
    int r;
    case (mode)
      1: return 16'h4000;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: begin
        r = $urandom_range(0, 2);
        if (r == 0) return 16'h7FFF;
        if (r == 1) return 16'h8000;
        return 16'($urandom);
      end
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < QN; i++) begin
      lfq[i] = pick(mode);
      hfq[i] = pick(mode);
    end
    for (int i = 0; i < 2*TAPS; i++) rom[i] = pick(mode);
  endtask

  // Filter result from the arithmetic definition: sum of products, Q1.15 scaling.
  function automatic logic [15:0] ref_result(input bit lf, input int base);
    longint sum;
    longint a;
    longint b;
    longint q;
    logic [63:0] qv;
    sum = 0;
    for (int k = 0; k < TAPS; k++) begin
      a = lf ? lfq[(base + k) % QN] : hfq[(base + k) % QN];
      b = rom[lf ? k : TAPS + k];
      sum += a * b;
    end
    q = sum >>> 15;
`ifdef BAND_FIR_SAT_EN
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
`endif
    qv = q;
    return qv[15:0];
  endfunction

  task automatic model_reset();
    active     = 1'b0;
    t          = 0;
    cur_lf     = 1'b0;
    last_lf    = 1'b0;
    cur_res    = '0;
    exp_lf_out = '0;
    exp_hf_out = '0;
  endtask

  // One clock edge of the pass-level model. t counts edges since the start edge.
  task automatic model_edge(input bit lreq, input bit hreq);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (active) begin
      t++;
      if (t == TAPS + 3) active = 1'b0;
    end else if (lreq || hreq) begin
      active  = 1'b1;
      t       = 0;
      cur_lf  = lreq && (!hreq || !last_lf);
      cur_res = ref_result(cur_lf, cur_lf ? lf_ptr : hf_ptr);
    end
    if (active && t == TAPS + 2) begin
      if (cur_lf) exp_lf_out = cur_res;
      else        exp_hf_out = cur_res;
      last_lf = cur_lf;
    end
  endtask

  task automatic compare_all();
    bit run;
    run = active && (t < TAPS);
    check("lf_gnt", lf_gnt, run && cur_lf);
    check("hf_gnt", hf_gnt, run && !cur_lf);
    check("coeff_addr", coeff_addr, run ? (cur_lf ? t : TAPS + t) : 0);
    check("lf_vld", lf_vld, active && t == TAPS + 2 && cur_lf);
    check("hf_vld", hf_vld, active && t == TAPS + 2 && !cur_lf);
    check("lf_out", lf_out, exp_lf_out);
    check("hf_out", hf_out, exp_hf_out);
  endtask

  // Drive requests, advance one clock, serve memory reads, then check.
  task automatic cycle(input bit lreq, input bit hreq);
    bit pg_lf;
    bit pg_hf;
    logic [CA_W-1:0] pa;
    lf_seq = lreq;
    hf_seq = hreq;
    pg_lf  = lf_gnt;
    pg_hf  = hf_gnt;
    pa     = coeff_addr;
    @(posedge clk);
    #1;
    if (pg_lf) begin
      lf_smpl = lfq[lf_ptr];
      lf_ptr  = (lf_ptr + 1) % QN;
    end
    if (pg_hf) begin
      hf_smpl = hfq[hf_ptr];
      hf_ptr  = (hf_ptr + 1) % QN;
    end
    coeff = rom[pa];
    model_edge(lreq, hreq);
    compare_all();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_gnt"}, {lf_gnt, hf_gnt}, 0);
    check({pfx, "_addr"}, coeff_addr, 0);
    check({pfx, "_vld"}, {lf_vld, hf_vld}, 0);
    check({pfx, "_out"}, {lf_out, hf_out}, 0);
  endtask

  task automatic drain();
    repeat (TAPS + 6) cycle(1'b0, 1'b0);
  endtask

  initial begin
    bit rl;
    bit rh;
    checks = 0;
    errors = 0;
    lf_ptr = 0;
    hf_ptr = 0;
    model_reset();
    fill(0);

    // reset state, then 100 idle cycles
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (100) cycle(1'b0, 1'b0);

    // single LF pass with 0x4000 data
    fill(1);
    cycle(1'b1, 1'b0);
    drain();

    // both held: LF, HF, LF in turn
    fill(0);
    repeat (3*(TAPS + 4)) cycle(1'b1, 1'b1);
    drain();

    // overflow with max-positive and max-negative operands
    fill(2);
    cycle(1'b1, 1'b0);
    drain();
    cycle(1'b0, 1'b1);
    drain();
    fill(3);
    cycle(1'b0, 1'b1);
    drain();

    // HF request dropped after one grant cycle
    fill(0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    drain();

    // randomized request levels, random and extreme data
    for (int pass = 0; pass < 2; pass++) begin
      fill(pass == 0 ? 0 : 4);
      rl = 1'b0;
      rh = 1'b0;
      repeat (400) begin
        if ($urandom_range(0, 7) == 0) rl = !rl;
        if ($urandom_range(0, 7) == 0) rh = !rh;
        cycle(rl, rh);
      end
      drain();
    end

    // reset while the third tap is being granted
    fill(0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("pre_rst_gnt", lf_gnt, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
